// File: rtl/multiword_adder_seq.sv
// Multi-cycle wide adder: walks two WIDTH-bit operands through a CHUNK-bit adder
// one word per cycle, rippling the carry through a register between words.
module multiword_adder_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_acc_next;

  assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_c};

  // New chunk enters at the top so that after NCHUNK shifts chunk 0 sits at the LSB.
  assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_c      <= cin;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_c   <= w_chunk[CHUNK];
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            sum       <= w_acc_next;
            cout      <= w_chunk[CHUNK];
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; a new op cannot be taken on the handoff edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: directed vectors, backpressure, mid-run reset,
// random traffic against a scoreboard, plus a single-chunk instance.
module tb_multiword_adder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;

  int checks = 0;
  int errors = 0;
  int nacc   = 0;
  int nres   = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  multiword_adder_seq #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  multiword_adder_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push the exact 33-bit sum at accept, compare at handoff.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("ready_valid_excl", {63'd0, in_ready & out_valid}, 64'd0);
      if (in_valid && in_ready) begin
        check("accept_while_busy", sb.size(), 0);
        sb.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
        nacc++;
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) check("sb_result", {cout, sum}, sb.pop_front());
        nres++;
      end
    end
  end

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int cyc;
    int sent;
    int base_acc;
    int base_res;
    bit fire;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[6] = '{32'h0000000F, 32'h00000000, 1'b1, 32'h00000010, 1'b0};
    vecs[7] = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_in_ready8", {63'd0, in_ready8}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; each also checks the accept-to-out_valid latency.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_sum", i), {32'd0, sum}, {32'd0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {63'd0, cout}, {63'd0, vecs[i].cout});
      $display("vec %0d: a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, sum, cout, lat);
      finish_op();
    end

    // Backpressure: result held while a new op waits on in_valid.
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done(lat);
    a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_sum", {32'd0, sum}, 64'h00000000ACF13569);
      check("bp_cout", {63'd0, cout}, 64'd0);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", {63'd0, in_ready}, 64'd1);
    check("bp_idle_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", {63'd0, in_ready}, 64'd0);
    wait_done(lat);
    check("bp_new_latency", lat, 8);
    check("bp_new_sum", {32'd0, sum}, 64'h0000000033333333);
    check("bp_new_cout", {63'd0, cout}, 64'd0);
    $display("backpressure: held ACF13569, then sum=%h cout=%0d", sum, cout);
    finish_op();

    // Reset three cycles into RUN aborts the op and clears the outputs at once.
    start_op(32'hDEADBEEF, 32'h01010101, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", {32'd0, sum}, 64'd0);
    check("midrst_cout", {63'd0, cout}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_op(32'h5, 32'h7, 1'b0);
    wait_done(lat);
    check("post_rst_sum", {32'd0, sum}, 64'hC);
    check("post_rst_cout", {63'd0, cout}, 64'd0);
    $display("mid-run reset: next op 5+7 -> sum=%h cout=%0d", sum, cout);
    finish_op();

    // Single-chunk instance: one RUN cycle.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("n1_not_yet_valid", {63'd0, out_valid8}, 64'd0);
    @(posedge clk); #1;
    check("n1_out_valid", {63'd0, out_valid8}, 64'd1);
    check("n1_sum", {56'd0, sum8}, 64'h01);
    check("n1_cout", {63'd0, cout8}, 64'd1);
    $display("nchunk1: a=80 b=80 cin=1 -> sum=%h cout=%0d", sum8, cout8);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("n1_back_idle", {62'd0, in_ready8, out_valid8}, 64'b10);

    // Random traffic with gaps on both handshakes; the scoreboard does the checking.
    base_acc = nacc;
    base_res = nres;
    sent = 0;
    cyc = 0;
    while ((nres - base_res) < 1000 && cyc < 60000) begin
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        in_valid = 1'b0;
        sent++;
      end
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) == 0) begin
        a   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        b   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_results", nres - base_res, 1000);
    check("rand_accepts", nacc - base_acc, 1000);
    $display("random: %0d accepts, %0d results in %0d cycles", nacc - base_acc, nres - base_res, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
